// File: rtl/display_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types and constants for the multiplexed seven-segment
//             display driver: the active-high hex segment patterns (bit 0 =
//             segment a ... bit 6 = segment g), and the bit positions of the
//             dot and the first digit enable on the output bus.
//  Revision : 1.0  initial release
// ============================================================================
package display_pkg;

    typedef logic [6:0] seg_pattern_t;

    // Bit position of the decimal point and of digit 0's enable on segs.
    localparam int c_dot_bit = 7;
    localparam int c_en_base = 8;

    // Active-high patterns, g..a; 'E' and 'F' light both a and g.
    localparam seg_pattern_t c_hex_pat [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage
`default_nettype wire

// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_mux_if
//  Purpose  : Bundle between a display client (master) and the scan driver
//             (slave).
//  Ports    : digits/dots/blank/blink_en/load/lamp_test  master -> slave
//             segs (active-low, 8+N_DIGITS) / frame_start slave -> master
//  Revision : 1.0  initial release
// ============================================================================
interface display_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dots;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   blink_en;
    logic                  load;
    logic                  lamp_test;
    logic [8+N_DIGITS-1:0] segs;
    logic                  frame_start;

    modport master (
        output digits, dots, blank, blink_en, load, lamp_test,
        input  segs, frame_start
    );

    modport slave (
        input  digits, dots, blank, blink_en, load, lamp_test,
        output segs, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decoder
//  Purpose  : Combinational hex to seven-segment decoder, active-low output.
//  Ports    : i_hex     4-bit hex value
//             o_segs_n  7-bit segments g..a, 0 = lit
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decoder
    import display_pkg::*;
(
    input  wire logic [3:0] i_hex,
    output seg_pattern_t    o_segs_n
);

    assign o_segs_n = ~c_hex_pat[i_hex];

endmodule
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_mux
//  Purpose  : Multiplexed seven-segment scan driver. Captures digit values and
//             attributes into a pending bank on load, promotes them to the
//             active bank at frame boundaries, and scans one digit per slot
//             with a leading all-off interval to suppress ghosting.
//  Ports    : clk, rst_n (async, active-low)
//             bus  display_scan_mux_if.slave (inputs, segs, frame_start)
//  Revision : 1.0  initial release
// ============================================================================
module display_scan_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    display_scan_mux_if.slave     bus
);

    localparam int IDX_W = $clog2((N_DIGITS > 2) ? N_DIGITS : 2);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int FRM_W = $clog2((BLINK_FRAMES > 2) ? BLINK_FRAMES : 2);
    localparam int SEG_W = 8 + N_DIGITS;

    localparam logic [CNT_W-1:0] c_cnt_last    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_start = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] c_idx_last    = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] c_frm_last    = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [FRM_W-1:0]      r_frm;
    logic                  r_phase;

    logic [4*N_DIGITS-1:0] r_pend_digits, r_act_digits;
    logic [N_DIGITS-1:0]   r_pend_dots,   r_act_dots;
    logic [N_DIGITS-1:0]   r_pend_blank,  r_act_blank;
    logic [N_DIGITS-1:0]   r_pend_blink,  r_act_blink;

    logic [SEG_W-1:0]      r_segs;
    logic                  r_frame_start;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [3:0]            w_sel_hex;
    logic                  w_sel_dot;
    logic                  w_sel_blank;
    logic                  w_sel_blink;
    logic                  w_dark;
    seg_pattern_t          w_dec_n;
    logic [SEG_W-1:0]      w_segs_next;

    assign w_tick      = (r_cnt == c_cnt_last);
    assign w_frame_end = w_tick && (r_idx == c_idx_last);

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame counter and blink phase; phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm   <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frm == c_frm_last) begin
                r_frm   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frm <= r_frm + 1'b1;
            end
        end
    end

    // Pending/active banks. A load on the boundary edge bypasses the pending
    // bank so the new values are shown in the frame that is just starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_digits <= '0;
            r_pend_dots   <= '0;
            r_pend_blank  <= '0;
            r_pend_blink  <= '0;
            r_act_digits  <= '0;
            r_act_dots    <= '0;
            r_act_blank   <= '0;
            r_act_blink   <= '0;
        end else begin
            if (bus.load) begin
                r_pend_digits <= bus.digits;
                r_pend_dots   <= bus.dots;
                r_pend_blank  <= bus.blank;
                r_pend_blink  <= bus.blink_en;
            end
            if (w_frame_end) begin
                r_act_digits <= bus.load ? bus.digits   : r_pend_digits;
                r_act_dots   <= bus.load ? bus.dots     : r_pend_dots;
                r_act_blank  <= bus.load ? bus.blank    : r_pend_blank;
                r_act_blink  <= bus.load ? bus.blink_en : r_pend_blink;
            end
        end
    end

    // Select the attributes of the digit currently being scanned.
    always_comb begin
        w_sel_hex   = '0;
        w_sel_dot   = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_blink = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel_hex   = r_act_digits[4*k +: 4];
                w_sel_dot   = r_act_dots[k];
                w_sel_blank = r_act_blank[k];
                w_sel_blink = r_act_blink[k];
            end
        end
    end

    assign w_dark = w_sel_blank || (w_sel_blink && r_phase);

    seg7_hex_decoder u_dec (
        .i_hex    (w_sel_hex),
        .o_segs_n (w_dec_n)
    );

    // Next output word; enables are gated by slot timing only, never by the
    // blank/blink/lamp attributes.
    always_comb begin
        w_segs_next = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((r_idx == IDX_W'(k)) && (r_cnt >= c_blank_start)) begin
                w_segs_next[c_en_base + k] = 1'b0;
            end
        end
        if (bus.lamp_test) begin
            w_segs_next[c_dot_bit:0] = '0;
        end else if (!w_dark) begin
            w_segs_next[6:0]       = w_dec_n;
            w_segs_next[c_dot_bit] = ~w_sel_dot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs        <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_segs        <= w_segs_next;
            r_frame_start <= w_frame_end;
        end
    end

    assign bus.segs        = r_segs;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
